// File: rtl/matrix_stream_reader.sv
// matrix_stream_reader
//
// Reads one stored matrix slot from the shared storage BRAM read port:
// fetches the three header words (rows/cols, name bytes 0..3, name bytes
// 4..7), validates the dimensions, then streams the rows*cols elements in
// row-major order over a valid/ready interface with full backpressure.
// Never touches the BRAM write side.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           read request, only honoured in IDLE
//   matrix_id_i       slot to read (captured with start_i)
//   busy_o            high while the header/stream phases run
//   done_o            one-cycle completion pulse
//   error_o           valid with done_o: header rejected
//   rows_o, cols_o    header dimensions (held until the next accepted start)
//   name_o            header name, byte k in bits [8k+7:8k]
//   read_addr_o       BRAM read address
//   bram_data_i       BRAM read data, one cycle after read_addr_o
//   out_data_o        streamed element
//   out_valid_o       out_data_o is valid
//   out_ready_i       consumer accepts the current element
//   out_last_o        current element is the final one
//
// Slot layout: base = id*BLOCK_SIZE; base+0 = {cols,rows}, base+1/base+2 =
// name bytes, base+3.. = elements. DATA_WIDTH must be at least 32.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_i; read_addr_o holds its last value
// S_HDR    | phase 0..2 present base+0..2, captures lag one cycle; phase 3
//          | captures the last header word, judges it, and already
//          | presents the first element address
// S_STREAM | credit-limited element reads into a 2-entry FIFO
// S_FIN    | done_o pulse, then back to S_IDLE

module matrix_stream_reader #(
   parameter int BLOCK_SIZE = 1152,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [2:0]            matrix_id_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [7:0]            rows_o,
   output logic [7:0]            cols_o,
   output logic [63:0]           name_o,
   output logic [ADDR_WIDTH-1:0] read_addr_o,
   input  logic [DATA_WIDTH-1:0] bram_data_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_last_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HDR    = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_FIN    = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] BLOCK_A   = ADDR_WIDTH'(BLOCK_SIZE);
   localparam logic [15:0]           MAX_ELEMS = 16'(BLOCK_SIZE - 3);

   logic [1:0]            state_q, state_d;
   logic [1:0]            phase_q, phase_d;
   logic [2:0]            id_q, id_d;
   logic                  error_q, error_d;
   logic [7:0]            rows_q, rows_d;
   logic [7:0]            cols_q, cols_d;
   logic [63:0]           name_q, name_d;
   logic [15:0]           n_q, n_d;
   logic [15:0]           issue_cnt_q, issue_cnt_d;
   logic [15:0]           out_cnt_q, out_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_pend_q, rd_pend_d;

   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;

   logic [ADDR_WIDTH-1:0] base;
   logic [15:0]           prod;
   logic [2:0]            credit;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  head_last;

   assign base = ADDR_WIDTH'(id_q) * BLOCK_A;
   assign prod = {8'd0, rows_q} * {8'd0, cols_q};

   assign out_valid_o = (fifo_cnt_q != 2'd0);
   assign out_data_o  = fifo_q[rd_ptr_q];
   assign head_last   = (out_cnt_q == (n_q - 16'd1));
   assign out_last_o  = out_valid_o && head_last;

   assign pop  = out_valid_o && out_ready_i;
   // Data for a read presented last cycle is on bram_data_i now; only
   // element reads made while streaming are kept (the speculative first read
   // of a rejected header is simply dropped).
   assign push = rd_pend_q && (state_q == S_STREAM);

   // Buffered plus in-flight elements, counting the slot a pop frees this
   // cycle; keeping it below 2 bounds storage at 2 while still allowing one
   // read per cycle when the consumer keeps up.
   assign credit = 3'(fifo_cnt_q) + {2'b00, rd_pend_q} - {2'b00, pop};

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      id_d        = id_q;
      error_d     = error_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      name_d      = name_q;
      n_d         = n_q;
      issue_cnt_d = issue_cnt_q;
      out_cnt_d   = out_cnt_q;
      addr_d      = addr_q;
      issue       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_HDR;
               phase_d     = 2'd0;
               id_d        = matrix_id_i;
               error_d     = 1'b0;
               issue_cnt_d = 16'd0;
               out_cnt_d   = 16'd0;
            end
         end

         S_HDR: begin
            phase_d = phase_q + 2'd1;
            case (phase_q)
               2'd0: addr_d = base;
               2'd1: begin
                  addr_d = base + ADDR_WIDTH'(1);
                  rows_d = bram_data_i[7:0];
                  cols_d = bram_data_i[15:8];
               end
               2'd2: begin
                  addr_d        = base + ADDR_WIDTH'(2);
                  name_d[31:0]  = bram_data_i[31:0];
               end
               default: begin
                  name_d[63:32] = bram_data_i[31:0];
                  n_d           = prod;
                  // Any valid header has at least one element, so element 0
                  // can be requested before the verdict is known.
                  issue         = 1'b1;
                  addr_d        = base + ADDR_WIDTH'(3);
                  issue_cnt_d   = 16'd1;
                  if ((rows_q == 8'd0) || (cols_q == 8'd0) || (prod > MAX_ELEMS)) begin
                     error_d = 1'b1;
                     state_d = S_FIN;
                  end else begin
                     state_d = S_STREAM;
                  end
               end
            endcase
         end

         S_STREAM: begin
            if ((issue_cnt_q < n_q) && (credit < 3'd2)) begin
               issue       = 1'b1;
               addr_d      = base + ADDR_WIDTH'(3) + ADDR_WIDTH'(issue_cnt_q);
               issue_cnt_d = issue_cnt_q + 16'd1;
            end
            if (pop) begin
               out_cnt_d = out_cnt_q + 16'd1;
               if (head_last) begin
                  state_d = S_FIN;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rd_pend_d = issue;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         phase_q     <= 2'd0;
         id_q        <= 3'd0;
         error_q     <= 1'b0;
         rows_q      <= 8'd0;
         cols_q      <= 8'd0;
         name_q      <= 64'd0;
         n_q         <= 16'd0;
         issue_cnt_q <= 16'd0;
         out_cnt_q   <= 16'd0;
         addr_q      <= '0;
         rd_pend_q   <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fifo_cnt_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         id_q        <= id_d;
         error_q     <= error_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         name_q      <= name_d;
         n_q         <= n_d;
         issue_cnt_q <= issue_cnt_d;
         out_cnt_q   <= out_cnt_d;
         addr_q      <= addr_d;
         rd_pend_q   <= rd_pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= bram_data_i;
         end
      end
   end

   // The address is presented in the same cycle the read decision is made,
   // so the BRAM latency plus one FIFO cycle is the whole read-to-beat loop.
   assign read_addr_o = addr_d;

   assign busy_o  = (state_q == S_HDR) || (state_q == S_STREAM);
   assign done_o  = (state_q == S_FIN);
   assign error_o = error_q;
   assign rows_o  = rows_q;
   assign cols_o  = cols_q;
   assign name_o  = name_q;

endmodule
